// File: rtl/data_mem_bytelane_pkg.sv
// Shared types for the byte-lane data memory: access sizes, fault codes and
// sequencer states, plus the load extension helper.
package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    F_OK       = 2'b00,
    F_MISALIGN = 2'b01,
    F_RANGE    = 2'b10,
    F_SIZE     = 2'b11
  } fault_t;

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_CLEAR = 2'b01,
    ST_RUN   = 2'b10
  } mem_state_t;

  localparam int LANES = 4;

  // Widens a byte (half=0, uses v[7:0]) or halfword (half=1) to 32 bits.
  function automatic logic [31:0] extend(input logic [15:0] v,
                                         input logic        half,
                                         input logic        is_unsigned);
    logic [31:0] r;
    if (half) begin
      r = {{16{v[15] & ~is_unsigned}}, v};
    end else begin
      r = {{24{v[7] & ~is_unsigned}}, v[7:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/data_mem_bytelane_if.sv
// Request/response bus of the data memory.
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; the requester holds all req_* fields stable while
// req_valid is high and req_ready is low. Responses have no backpressure:
// rsp_valid is a one-cycle pulse, one per accepted request, in request order.
interface data_mem_bytelane_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_fault;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/data_mem_bytelane_align.sv
// Byte-lane steering: store lane mask and positioned write data, load lane
// extraction with sign/zero extension, and the alignment check.
module data_mem_align
  import data_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  lane_mask,
  output logic [31:0] wdata_pos,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword[{addr_lo, 3'b000} +: 8];
  assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    lane_mask = 4'b0000;
    wdata_pos = '0;
    rdata_ext = '0;
    misalign  = 1'b0;
    case (size_t'(size))
      SZ_B: begin
        lane_mask = 4'b0001 << addr_lo;
        wdata_pos = {4{wdata[7:0]}};
        rdata_ext = extend({8'h00, rbyte}, 1'b0, is_unsigned);
      end
      SZ_H: begin
        misalign  = addr_lo[0];
        lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_pos = {2{wdata[15:0]}};
        rdata_ext = extend(rhalf, 1'b1, is_unsigned);
      end
      SZ_W: begin
        misalign  = |addr_lo;
        lane_mask = 4'b1111;
        wdata_pos = wdata;
        rdata_ext = rword;
      end
      default: begin
        // Illegal size: no lanes, no data; the fault logic reports it.
        lane_mask = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_bytelane.sv
// Byte-addressable data memory with per-lane stores, sign/zero-extended loads,
// a post-reset zero-fill sequencer and a fixed-latency response pipeline.
module data_mem_bytelane
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS    = 1024,
  parameter int RD_LATENCY     = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_bytelane_if.slave   bus,
  output logic                 clear_busy,
  output mem_state_t           dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  mem_state_t    state_q;
  mem_state_t    state_d;
  logic [AW-1:0] clr_cnt;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic [AW-1:0] widx;
  logic          out_of_range;
  logic [31:0]   rword;
  logic [3:0]    lane_mask;
  logic [31:0]   wdata_pos;
  logic [31:0]   rdata_ext;
  logic          misalign;
  fault_t        fault;
  logic          do_write;
  logic [31:0]   rsp_data;

  logic          pipe_v [RD_LATENCY];
  logic [31:0]   pipe_d [RD_LATENCY];
  fault_t        pipe_f [RD_LATENCY];

  // ---------------- sequencer ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  state_d = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      ST_CLEAR: if (clr_cnt == AW'(DEPTH_WORDS - 1)) state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_INIT;
    endcase
  end

  // The counter only advances while clearing, so a reset mid-clear restarts at word 0.
  always_ff @(posedge clk) begin
    if (rst || state_q != ST_CLEAR) begin
      clr_cnt <= '0;
    end else begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  assign clear_busy    = (state_q == ST_INIT) || (state_q == ST_CLEAR);
  assign dbg_state     = state_q;
  assign bus.req_ready = (state_q == ST_RUN);

  // ---------------- request decode ----------------
  assign accept       = bus.req_valid && bus.req_ready;
  assign widx         = bus.req_addr[AW+1:2];
  assign out_of_range = |bus.req_addr[31:AW+2];
  assign rword        = mem[widx];

  data_mem_align u_align (
    .addr_lo     (bus.req_addr[1:0]),
    .size        (bus.req_size),
    .is_unsigned (bus.req_unsigned),
    .wdata       (bus.req_wdata),
    .rword       (rword),
    .lane_mask   (lane_mask),
    .wdata_pos   (wdata_pos),
    .rdata_ext   (rdata_ext),
    .misalign    (misalign)
  );

  // Illegal size outranks misalignment, which outranks range.
  always_comb begin
    fault = F_OK;
    if (bus.req_size == 2'b11) begin
      fault = F_SIZE;
    end else if (misalign) begin
      fault = F_MISALIGN;
    end else if (out_of_range) begin
      fault = F_RANGE;
    end
  end

  assign do_write = accept && bus.req_we && (fault == F_OK);
  assign rsp_data = (accept && !bus.req_we && (fault == F_OK)) ? rdata_ext : 32'h0;

  // ---------------- storage ----------------
  // A store on a reset edge is dropped; the array itself is not reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (do_write) begin
        for (int i = 0; i < LANES; i++) begin
          if (lane_mask[i]) begin
            mem[widx][8*i +: 8] <= wdata_pos[8*i +: 8];
          end
        end
      end
    end
  end

  // ---------------- response pipeline ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_d[i] <= '0;
        pipe_f[i] <= F_OK;
      end
    end else begin
      pipe_v[0] <= accept;
      pipe_d[0] <= rsp_data;
      pipe_f[0] <= accept ? fault : F_OK;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
        pipe_f[i] <= pipe_f[i-1];
      end
    end
  end

  assign bus.rsp_valid = pipe_v[RD_LATENCY-1];
  assign bus.rsp_rdata = pipe_d[RD_LATENCY-1];
  assign bus.rsp_fault = pipe_f[RD_LATENCY-1];

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Directed bench: a 16-word, latency-3 clearing instance (dut_a) and a
// 16-word, latency-1 non-clearing instance (dut_n).
module tb_data_mem_bytelane;
  import data_mem_pkg::*;

  localparam int DEPTH = 16;
  localparam int LAT_A = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a;
  logic       rst_n;
  logic       busy_a;
  logic       busy_n;
  mem_state_t st_a;
  mem_state_t st_n;

  data_mem_bytelane_if bus_a ();
  data_mem_bytelane_if bus_n ();

  data_mem_bytelane #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(LAT_A), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a), .clear_busy(busy_a), .dbg_state(st_a)
  );

  data_mem_bytelane #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(1), .CLEAR_ON_RESET(1'b0)) dut_n (
    .clk(clk), .rst(rst_n), .bus(bus_n), .clear_busy(busy_n), .dbg_state(st_n)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          exp_t[$];
  int          spurious = 0;
  bit          mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && bus_a.rsp_valid) spurious++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit on_n, input logic v, input logic we, input logic [31:0] addr,
                       input logic [1:0] sz, input logic uns, input logic [31:0] wd);
    if (on_n) begin
      bus_n.req_valid = v; bus_n.req_we = we; bus_n.req_addr = addr;
      bus_n.req_size = sz; bus_n.req_unsigned = uns; bus_n.req_wdata = wd;
    end else begin
      bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_addr = addr;
      bus_a.req_size = sz; bus_a.req_unsigned = uns; bus_a.req_wdata = wd;
    end
  endtask

  function automatic logic rdy(input bit on_n);
    return on_n ? bus_n.req_ready : bus_a.req_ready;
  endfunction

  function automatic logic rv(input bit on_n);
    return on_n ? bus_n.rsp_valid : bus_a.rsp_valid;
  endfunction

  // Called at a negedge just after reset release; counts edges until ready.
  task automatic wait_ready(input bit on_n, output int n);
    n = 0;
    while (!rdy(on_n) && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One request at a negedge, then wait for its response and check it.
  task automatic op(input string tag, input bit on_n, input logic we, input logic [31:0] addr,
                    input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                    input logic [31:0] exp_d, input logic [1:0] exp_f);
    int n;
    int lat;
    lat = on_n ? 1 : LAT_A;
    wait_ready(on_n, n);
    drive(on_n, 1'b1, we, addr, sz, uns, wd);
    @(negedge clk);
    drive(on_n, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    n = 1;
    while (!rv(on_n) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_d"}, on_n ? bus_n.rsp_rdata : bus_a.rsp_rdata, exp_d);
    check({tag, "_f"}, {30'd0, on_n ? bus_n.rsp_fault : bus_a.rsp_fault}, {30'd0, exp_f});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int extra;
    rst_a = 1'b1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    repeat (3) @(negedge clk);

    check("rst_ready", {31'd0, bus_a.req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus_a.rsp_valid}, 32'd0);
    check("rst_rdata", bus_a.rsp_rdata, 32'h0);
    check("rst_fault", {30'd0, bus_a.rsp_fault}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd1);
    check("rst_state", {30'd0, st_a}, {30'd0, ST_INIT});

    rst_a = 1'b0;
    wait_ready(1'b0, n);
    check("clr_delay", n, DEPTH + 1);
    check("clr_busy_done", {31'd0, busy_a}, 32'd0);
    op("lw_3c", 1'b0, 1'b0, 32'h3C, SZ_W, 1'b0, 32'h0, 32'h00000000, F_OK);

    // Byte/half extraction from a known word.
    op("sw_8",   1'b0, 1'b1, 32'h8, SZ_W, 1'b0, 32'h80FF7F01, 32'h0, F_OK);
    op("lb_8",   1'b0, 1'b0, 32'h8, SZ_B, 1'b0, 32'h0, 32'h00000001, F_OK);
    op("lb_b",   1'b0, 1'b0, 32'hB, SZ_B, 1'b0, 32'h0, 32'hFFFFFF80, F_OK);
    op("lbu_b",  1'b0, 1'b0, 32'hB, SZ_B, 1'b1, 32'h0, 32'h00000080, F_OK);
    op("lh_a",   1'b0, 1'b0, 32'hA, SZ_H, 1'b0, 32'h0, 32'hFFFF80FF, F_OK);
    op("lhu_a",  1'b0, 1'b0, 32'hA, SZ_H, 1'b1, 32'h0, 32'h000080FF, F_OK);
    op("lh_8",   1'b0, 1'b0, 32'h8, SZ_H, 1'b0, 32'h0, 32'h00007F01, F_OK);

    // Partial stores leave other lanes alone.
    op("sb_9",   1'b0, 1'b1, 32'h9, SZ_B, 1'b0, 32'h123456AA, 32'h0, F_OK);
    op("lw_sb",  1'b0, 1'b0, 32'h8, SZ_W, 1'b0, 32'h0, 32'h80FFAA01, F_OK);
    op("sh_a",   1'b0, 1'b1, 32'hA, SZ_H, 1'b0, 32'hFFFF1234, 32'h0, F_OK);
    op("lw_sh",  1'b0, 1'b0, 32'h8, SZ_W, 1'b0, 32'h0, 32'h1234AA01, F_OK);

    // Faults, each followed by a readback.
    op("lw_6",   1'b0, 1'b0, 32'h6, SZ_W, 1'b0, 32'h0, 32'h0, F_MISALIGN);
    op("chk1",   1'b0, 1'b0, 32'h8, SZ_W, 1'b0, 32'h0, 32'h1234AA01, F_OK);
    op("lh_5",   1'b0, 1'b0, 32'h5, SZ_H, 1'b0, 32'h0, 32'h0, F_MISALIGN);
    op("chk2",   1'b0, 1'b0, 32'h8, SZ_W, 1'b0, 32'h0, 32'h1234AA01, F_OK);
    op("sw_oor", 1'b0, 1'b1, 32'(4 * DEPTH), SZ_W, 1'b0, 32'hDEADBEEF, 32'h0, F_RANGE);
    op("chk3",   1'b0, 1'b0, 32'h8, SZ_W, 1'b0, 32'h0, 32'h1234AA01, F_OK);
    op("chk3_w0", 1'b0, 1'b0, 32'h0, SZ_W, 1'b0, 32'h0, 32'h0, F_OK);
    op("sz11_9", 1'b0, 1'b1, 32'h9, 2'b11, 1'b0, 32'hFFFFFFFF, 32'h0, F_SIZE);
    op("chk4",   1'b0, 1'b0, 32'h8, SZ_W, 1'b0, 32'h0, 32'h1234AA01, F_OK);
    op("lw_oor", 1'b0, 1'b0, 32'h0000_1008, SZ_W, 1'b0, 32'h0, 32'h0, F_RANGE);

    // Back-to-back SW then LW; idx counts negedges after the SW's accept edge.
    drive(1'b0, 1'b1, 1'b1, 32'h10, SZ_W, 1'b0, 32'h5);
    exp_q.push_back(32'h0); exp_t.push_back(3);
    exp_q.push_back(32'h5); exp_t.push_back(4);
    extra = 0;
    for (int idx = 1; idx <= 8; idx++) begin
      @(negedge clk);
      if (idx == 1) drive(1'b0, 1'b1, 1'b0, 32'h10, SZ_W, 1'b0, 32'h0);
      if (idx == 2) drive(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
      if (bus_a.rsp_valid) begin
        if (exp_q.size() == 0) begin
          extra++;
        end else begin
          check("b2b_d", bus_a.rsp_rdata, exp_q.pop_front());
          check("b2b_t", idx, exp_t.pop_front());
          check("b2b_f", {30'd0, bus_a.rsp_fault}, 32'd0);
        end
      end
    end
    check("b2b_extra", extra, 0);
    check("b2b_left", exp_q.size(), 0);

    // Reset with two loads in flight, then again mid-clear.
    drive(1'b0, 1'b1, 1'b0, 32'h8, SZ_W, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    rst_a  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_flush", {31'd0, bus_a.rsp_valid}, 32'd0);
    rst_a = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_state", {30'd0, st_a}, {30'd0, ST_CLEAR});
    check("mid_busy", {31'd0, busy_a}, 32'd1);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    wait_ready(1'b0, n);
    check("reclr_delay", n, DEPTH + 1);
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    check("no_rsp", spurious, 0);
    op("post_clr", 1'b0, 1'b0, 32'h8, SZ_W, 1'b0, 32'h0, 32'h0, F_OK);

    // Non-clearing, latency-1 instance; a store on a reset edge is dropped.
    check("n_rst_busy", {31'd0, busy_n}, 32'd1);
    rst_n = 1'b0;
    wait_ready(1'b1, n);
    check("n_ready_delay", n, 1);
    op("n_sw4",  1'b1, 1'b1, 32'h4, SZ_W, 1'b0, 32'h11111111, 32'h0, F_OK);
    op("n_lw4",  1'b1, 1'b0, 32'h4, SZ_W, 1'b0, 32'h0, 32'h11111111, F_OK);
    op("n_lhu6", 1'b1, 1'b0, 32'h6, SZ_H, 1'b1, 32'h0, 32'h00001111, F_OK);
    drive(1'b1, 1'b1, 1'b1, 32'h4, SZ_W, 1'b0, 32'h22222222);
    rst_n = 1'b1;
    @(negedge clk);
    check("n_rst_v", {31'd0, bus_n.rsp_valid}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    rst_n = 1'b0;
    wait_ready(1'b1, n);
    check("n_ready_delay2", n, 1);
    op("n_lw4b", 1'b1, 1'b0, 32'h4, SZ_W, 1'b0, 32'h0, 32'h11111111, F_OK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
